// File: rtl/lc3_pipeline_stage1.sv
// rtl/lc3_pipeline_stage1.sv - LC-3 decode stage: decode register, decoder, load-use hazard, flush/stall FSM
// Optional feature macro: LC3_DECODE_ILLEGAL_EN (adds the illegal output for reserved opcode 1101)
module lc3_pipeline_stage1 #(
    parameter logic [15:0] RESET_PC = 16'h0060
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_pc,
    input  logic [15:0] in_npc,
    input  logic [15:0] in_inst,
    input  logic        stall_in,
    input  logic        flush,
    input  logic [2:0]  ex_dr,
    input  logic        ex_is_load,
    output logic        stall_out,
    output logic        valid,
    output logic [15:0] pc,
    output logic [15:0] npc,
    output logic [15:0] inst,
    output logic [3:0]  opcode,
    output logic [2:0]  dr,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic        use_imm,
    output logic [15:0] imm16,
    output logic        ld_reg,
    output logic        ld_cc,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        is_ctrl,
`ifdef LC3_DECODE_ILLEGAL_EN
    output logic        illegal,
`endif
    output logic        hazard
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_valid;
    logic [15:0] r_pc;
    logic [15:0] r_npc;
    logic [15:0] r_inst;

    logic [3:0]  w_op;
    logic [2:0]  w_dr;
    logic [2:0]  w_sr2;
    logic [15:0] w_imm;
    logic        w_use_imm;
    logic        w_ld_reg;
    logic        w_ld_cc;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic        w_ctrl;
    logic        w_reads_sr2;
    logic        w_hazard;
    logic        w_bubble;
    logic        w_illegal;

    // Register updates on the falling edge to line up with fetch.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_npc   <= RESET_PC + 16'd1;
            r_inst  <= 16'h0000;
        end else if (flush) begin
            r_state <= ST_RUN;
            r_valid <= 1'b0;
        end else if (stall_in) begin
            r_state <= ST_HOLD;
        end else if (r_state == ST_BUBBLE) begin
            r_state <= ST_RUN;
        end else if (w_hazard) begin
            r_state <= ST_BUBBLE;
        end else begin
            r_state <= ST_RUN;
            r_valid <= in_valid;
            if (in_valid) begin
                r_pc   <= in_pc;
                r_npc  <= in_npc;
                r_inst <= in_inst;
            end
        end
    end

    assign w_op = r_inst[15:12];

    always_comb begin
        w_dr        = r_inst[11:9];
        w_sr2       = r_inst[2:0];
        w_imm       = 16'h0000;
        w_use_imm   = 1'b0;
        w_ld_reg    = 1'b0;
        w_ld_cc     = 1'b0;
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        w_ctrl      = 1'b0;
        w_reads_sr2 = 1'b0;
        case (w_op)
            4'b0000: begin
                w_imm  = {{7{r_inst[8]}}, r_inst[8:0]};
                w_ctrl = |r_inst[11:9];
            end
            4'b0001, 4'b0101: begin
                w_imm       = {{11{r_inst[4]}}, r_inst[4:0]};
                w_use_imm   = r_inst[5];
                w_ld_reg    = 1'b1;
                w_ld_cc     = 1'b1;
                w_reads_sr2 = ~r_inst[5];
            end
            4'b1001: begin
                w_ld_reg = 1'b1;
                w_ld_cc  = 1'b1;
            end
            4'b0010, 4'b1010: begin
                w_imm    = {{7{r_inst[8]}}, r_inst[8:0]};
                w_ld_reg = 1'b1;
                w_ld_cc  = 1'b1;
                w_mem_rd = 1'b1;
            end
            4'b0110: begin
                w_imm    = {{10{r_inst[5]}}, r_inst[5:0]};
                w_ld_reg = 1'b1;
                w_ld_cc  = 1'b1;
                w_mem_rd = 1'b1;
            end
            4'b0011, 4'b1011: begin
                w_imm       = {{7{r_inst[8]}}, r_inst[8:0]};
                w_sr2       = r_inst[11:9];
                w_mem_wr    = 1'b1;
                w_reads_sr2 = 1'b1;
            end
            4'b0111: begin
                w_imm       = {{10{r_inst[5]}}, r_inst[5:0]};
                w_sr2       = r_inst[11:9];
                w_mem_wr    = 1'b1;
                w_reads_sr2 = 1'b1;
            end
            4'b0100: begin
                w_dr     = 3'd7;
                w_ld_reg = 1'b1;
                w_ctrl   = 1'b1;
                if (r_inst[11]) w_imm = {{5{r_inst[10]}}, r_inst[10:0]};
            end
            4'b1000, 4'b1100: begin
                w_ctrl = 1'b1;
            end
            4'b1110: begin
                w_imm    = {{7{r_inst[8]}}, r_inst[8:0]};
                w_ld_reg = 1'b1;
                w_ld_cc  = 1'b1;
            end
            4'b1111: begin
                w_dr     = 3'd7;
                w_imm    = {8'h00, r_inst[7:0]};
                w_ld_reg = 1'b1;
                w_ctrl   = 1'b1;
            end
            default: ;
        endcase
    end

    // Store data (sr2 = inst[11:9]) counts as a source for the load-use check.
    assign w_hazard = r_valid & ex_is_load &
                      ((ex_dr == r_inst[8:6]) | ((ex_dr == w_sr2) & w_reads_sr2));
    assign w_bubble = (r_state == ST_BUBBLE);

`ifdef LC3_DECODE_ILLEGAL_EN
    assign w_illegal = r_valid & (w_op == 4'b1101);
    assign illegal   = w_illegal;
`else
    assign w_illegal = 1'b0;
`endif

    assign stall_out = (stall_in | w_hazard) & ~flush;
    assign hazard    = w_hazard;
    assign valid     = r_valid;
    assign pc        = r_pc;
    assign npc       = r_npc;
    assign inst      = r_inst;
    assign opcode    = w_op;
    assign dr        = w_dr;
    assign sr1       = r_inst[8:6];
    assign sr2       = w_sr2;
    assign imm16     = w_imm;
    assign use_imm   = r_valid & w_use_imm;
    assign ld_reg    = r_valid & w_ld_reg & ~w_bubble & ~w_illegal;
    assign ld_cc     = r_valid & w_ld_cc & ~w_illegal;
    assign mem_rd    = r_valid & w_mem_rd & ~w_bubble & ~w_illegal;
    assign mem_wr    = r_valid & w_mem_wr & ~w_bubble & ~w_illegal;
    assign is_ctrl   = w_illegal | (r_valid & w_ctrl & ~w_bubble);

endmodule

// File: tb/tb_lc3_pipeline_stage1.sv
// tb/tb_lc3_pipeline_stage1.sv - directed self-checking bench for lc3_pipeline_stage1
module tb_lc3_pipeline_stage1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_pc;
    logic [15:0] in_npc;
    logic [15:0] in_inst;
    logic        stall_in;
    logic        flush;
    logic [2:0]  ex_dr;
    logic        ex_is_load;
    logic        stall_out;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] npc;
    logic [15:0] inst;
    logic [3:0]  opcode;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        use_imm;
    logic [15:0] imm16;
    logic        ld_reg;
    logic        ld_cc;
    logic        mem_rd;
    logic        mem_wr;
    logic        is_ctrl;
    logic        hazard;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    lc3_pipeline_stage1 #(.RESET_PC(16'h0060)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_npc(in_npc),
        .in_inst(in_inst), .stall_in(stall_in), .flush(flush), .ex_dr(ex_dr),
        .ex_is_load(ex_is_load), .stall_out(stall_out), .valid(valid), .pc(pc), .npc(npc),
        .inst(inst), .opcode(opcode), .dr(dr), .sr1(sr1), .sr2(sr2), .use_imm(use_imm),
        .imm16(imm16), .ld_reg(ld_reg), .ld_cc(ld_cc), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .is_ctrl(is_ctrl), .hazard(hazard)
    );

    always #5 clk = ~clk;

    // One falling edge passes between consecutive calls; sampling sits 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] p, input logic [15:0] w);
        in_valid = 1'b1;
        in_pc    = p;
        in_npc   = p + 16'd1;
        in_inst  = w;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_pc = 16'h0; in_npc = 16'h0; in_inst = 16'h0;
        stall_in = 1'b0; flush = 1'b0; ex_dr = 3'd0; ex_is_load = 1'b0;
        #1;
        tick(); tick();
        chk_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid got %h want 0", valid); else pass_cnt++;
        chk_cnt++; if (pc !== 16'h0060) $display("FAIL reset_pc got %h want 0060", pc); else pass_cnt++;
        chk_cnt++; if (npc !== 16'h0061) $display("FAIL reset_npc got %h want 0061", npc); else pass_cnt++;
        chk_cnt++; if (inst !== 16'h0000) $display("FAIL reset_inst got %h want 0000", inst); else pass_cnt++;
        chk_cnt++; if (stall_out !== 1'b0) $display("FAIL reset_stall_out got %h want 0", stall_out); else pass_cnt++;
        chk_cnt++; if ({ld_reg, mem_rd, mem_wr, is_ctrl} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {ld_reg, mem_rd, mem_wr, is_ctrl}); else pass_cnt++;
        reset = 1'b1;
        tick();
        chk_cnt++; if (valid !== 1'b0 || pc !== 16'h0060)
            $display("FAIL idle_after_reset got valid=%h pc=%h want 0/0060", valid, pc); else pass_cnt++;
    endtask

    task automatic test_decode_add();
        fetch(16'h3000, 16'h1262);
        tick();
        in_valid = 1'b0;
        chk_cnt++; if (valid !== 1'b1 || pc !== 16'h3000 || npc !== 16'h3001)
            $display("FAIL add_latch got v=%h pc=%h npc=%h want 1/3000/3001", valid, pc, npc); else pass_cnt++;
        chk_cnt++; if (dr !== 3'd1 || sr1 !== 3'd1)
            $display("FAIL add_regs got dr=%0d sr1=%0d want 1/1", dr, sr1); else pass_cnt++;
        chk_cnt++; if (use_imm !== 1'b1 || imm16 !== 16'h0002)
            $display("FAIL add_imm got use=%h imm=%h want 1/0002", use_imm, imm16); else pass_cnt++;
        chk_cnt++; if (ld_reg !== 1'b1 || ld_cc !== 1'b1 || mem_rd !== 1'b0 || is_ctrl !== 1'b0)
            $display("FAIL add_flags got %b want 1100", {ld_reg, ld_cc, mem_rd, is_ctrl}); else pass_cnt++;
        ex_is_load = 1'b1; ex_dr = 3'd2; #1;
        chk_cnt++; if (hazard !== 1'b0) $display("FAIL add_imm_no_sr2_hazard got %h want 0", hazard); else pass_cnt++;
        ex_dr = 3'd1; #1;
        chk_cnt++; if (hazard !== 1'b1) $display("FAIL add_sr1_hazard got %h want 1", hazard); else pass_cnt++;
        ex_is_load = 1'b0; #1;
        chk_cnt++; if (hazard !== 1'b0) $display("FAIL no_load_no_hazard got %h want 0", hazard); else pass_cnt++;
        tick();
        chk_cnt++; if (valid !== 1'b0) $display("FAIL idle_drops_valid got %h want 0", valid); else pass_cnt++;
    endtask

    task automatic test_load_use();
        fetch(16'h3001, 16'h1442);
        tick();
        fetch(16'h3002, 16'h5000);
        ex_is_load = 1'b1; ex_dr = 3'd1; #1;
        chk_cnt++; if (hazard !== 1'b1 || stall_out !== 1'b1)
            $display("FAIL lu_detect got hz=%h so=%h want 1/1", hazard, stall_out); else pass_cnt++;
        tick();
        ex_is_load = 1'b0; #1;
        chk_cnt++; if (inst !== 16'h1442 || valid !== 1'b1)
            $display("FAIL lu_hold got inst=%h v=%h want 1442/1", inst, valid); else pass_cnt++;
        chk_cnt++; if (ld_reg !== 1'b0 || is_ctrl !== 1'b0)
            $display("FAIL lu_bubble got ld_reg=%h is_ctrl=%h want 0/0", ld_reg, is_ctrl); else pass_cnt++;
        tick();
        chk_cnt++; if (inst !== 16'h1442 || ld_reg !== 1'b1)
            $display("FAIL lu_resume got inst=%h ld_reg=%h want 1442/1", inst, ld_reg); else pass_cnt++;
        chk_cnt++; if (sr2 !== 3'd2 || use_imm !== 1'b0)
            $display("FAIL lu_sr2 got sr2=%0d use_imm=%h want 2/0", sr2, use_imm); else pass_cnt++;
        ex_is_load = 1'b1; ex_dr = 3'd2; #1;
        chk_cnt++; if (hazard !== 1'b1) $display("FAIL lu_sr2_hazard got %h want 1", hazard); else pass_cnt++;
        ex_is_load = 1'b0; #1;
        tick();
        chk_cnt++; if (inst !== 16'h5000 || pc !== 16'h3002)
            $display("FAIL lu_next got inst=%h pc=%h want 5000/3002", inst, pc); else pass_cnt++;
    endtask

    task automatic test_stall();
        fetch(16'h4000, 16'h6A7F);
        tick();
        chk_cnt++; if (dr !== 3'd5 || imm16 !== 16'hFFFF || mem_rd !== 1'b1 || ld_reg !== 1'b1)
            $display("FAIL ldr_decode got dr=%0d imm=%h rd=%h lr=%h want 5/FFFF/1/1", dr, imm16, mem_rd, ld_reg); else pass_cnt++;
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch(16'h4001 + 16'(i), 16'h1000 + 16'(i));
            #1;
            chk_cnt++; if (stall_out !== 1'b1) $display("FAIL stall_out_%0d got %h want 1", i, stall_out); else pass_cnt++;
            tick();
            chk_cnt++; if (inst !== 16'h6A7F || pc !== 16'h4000)
                $display("FAIL stall_hold_%0d got inst=%h pc=%h want 6A7F/4000", i, inst, pc); else pass_cnt++;
        end
        stall_in = 1'b0;
        fetch(16'h4010, 16'h0FFF);
        tick();
        chk_cnt++; if (inst !== 16'h0FFF || pc !== 16'h4010)
            $display("FAIL stall_release got inst=%h pc=%h want 0FFF/4010", inst, pc); else pass_cnt++;
        chk_cnt++; if (is_ctrl !== 1'b1 || imm16 !== 16'hFFFF || ld_reg !== 1'b0)
            $display("FAIL br_decode got ctrl=%h imm=%h lr=%h want 1/FFFF/0", is_ctrl, imm16, ld_reg); else pass_cnt++;
    endtask

    task automatic test_flush();
        flush = 1'b1; stall_in = 1'b1;
        fetch(16'h4011, 16'h1262);
        #1;
        chk_cnt++; if (stall_out !== 1'b0) $display("FAIL flush_kills_stall got %h want 0", stall_out); else pass_cnt++;
        tick();
        flush = 1'b0; stall_in = 1'b0; in_valid = 1'b0; #1;
        chk_cnt++; if (valid !== 1'b0 || is_ctrl !== 1'b0 || ld_reg !== 1'b0)
            $display("FAIL flush_squash got v=%h ctrl=%h lr=%h want 0/0/0", valid, is_ctrl, ld_reg); else pass_cnt++;
        fetch(16'h5000, 16'h7283);
        tick();
        chk_cnt++; if (valid !== 1'b1 || inst !== 16'h7283)
            $display("FAIL flush_run got v=%h inst=%h want 1/7283", valid, inst); else pass_cnt++;
        chk_cnt++; if (mem_wr !== 1'b1 || sr2 !== 3'd1 || sr1 !== 3'd2 || imm16 !== 16'h0003 || ld_reg !== 1'b0)
            $display("FAIL str_decode got wr=%h sr2=%0d sr1=%0d imm=%h lr=%h want 1/1/2/0003/0", mem_wr, sr2, sr1, imm16, ld_reg); else pass_cnt++;
        ex_is_load = 1'b1; ex_dr = 3'd1; #1;
        chk_cnt++; if (hazard !== 1'b1) $display("FAIL store_data_hazard got %h want 1", hazard); else pass_cnt++;
        flush = 1'b1; #1;
        chk_cnt++; if (stall_out !== 1'b0) $display("FAIL flush_over_hazard got %h want 0", stall_out); else pass_cnt++;
        tick();
        flush = 1'b0; ex_is_load = 1'b0; in_valid = 1'b0; #1;
        chk_cnt++; if (valid !== 1'b0) $display("FAIL flush_hazard_valid got %h want 0", valid); else pass_cnt++;
    endtask

    task automatic test_immediates();
        fetch(16'h6000, 16'h4FFF);
        tick();
        chk_cnt++; if (imm16 !== 16'hFFFF || dr !== 3'd7 || is_ctrl !== 1'b1 || ld_reg !== 1'b1 || ld_cc !== 1'b0)
            $display("FAIL jsr got imm=%h dr=%0d ctrl=%h lr=%h cc=%h want FFFF/7/1/1/0", imm16, dr, is_ctrl, ld_reg, ld_cc); else pass_cnt++;
        fetch(16'h6001, 16'hF025);
        tick();
        chk_cnt++; if (imm16 !== 16'h0025 || dr !== 3'd7 || is_ctrl !== 1'b1)
            $display("FAIL trap got imm=%h dr=%0d ctrl=%h want 0025/7/1", imm16, dr, is_ctrl); else pass_cnt++;
        fetch(16'h6002, 16'h4080);
        tick();
        chk_cnt++; if (imm16 !== 16'h0000 || dr !== 3'd7 || sr1 !== 3'd2)
            $display("FAIL jsrr got imm=%h dr=%0d sr1=%0d want 0000/7/2", imm16, dr, sr1); else pass_cnt++;
        fetch(16'h6003, 16'h0100);
        tick();
        chk_cnt++; if (is_ctrl !== 1'b0 || opcode !== 4'h0)
            $display("FAIL br_never got ctrl=%h op=%h want 0/0", is_ctrl, opcode); else pass_cnt++;
        fetch(16'h6004, 16'hD123);
        tick();
        chk_cnt++; if ({ld_reg, ld_cc, mem_rd, mem_wr, is_ctrl} !== 5'b00000 || opcode !== 4'hD)
            $display("FAIL reserved got %b op=%h want 00000/D", {ld_reg, ld_cc, mem_rd, mem_wr, is_ctrl}, opcode); else pass_cnt++;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode_add();
        test_load_use();
        test_stall();
        test_flush();
        test_immediates();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
